switch_debounce3: RTL and testbench



---
 rtl/switch_debounce3.sv | 128 ++++++++++++
 tb/tb_switch_debounce3.sv | 300 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/switch_debounce3.sv
// -----------------------------------------------------------------------------
// switch_debounce3
//
// Three-channel switch conditioner for the lamp-control stage (S1/S2/S3).
// Each raw switch level passes through a two-flop synchroniser. A per-channel
// stability counter then only lets the clean level follow the synchronised
// input after DB_CYCLES consecutive disagreeing cycles. Any return to
// agreement clears the count, so no partial credit carries over.
//
// Optional feature (macro SWITCH_DEBOUNCE3_TOGGLE_EN):
//   defined   - push-button mode. Every qualified 0->1 transition of the
//               internal stable level toggles sw_db. Qualified 1->0
//               transitions only update the internal level.
//   undefined - level-switch mode. sw_db is the internal stable level.
//
// Parameters:
//   DB_CYCLES - consecutive disagreeing cycles before the output updates
//               (legal range 1 .. 2**CNT_W-1)
//   CNT_W     - width of each channel's stability counter
//
// Ports:
//   clk     - system clock, rising-edge active
//   rst     - asynchronous, active-high reset
//   sw_in   - raw switch levels (bit0->S1, bit1->S2, bit2->S3)
//   sw_db   - debounced levels driving lamp-control S1..S3
//   sw_chg  - registered one-cycle strobe per channel on each sw_db change
//   any_chg - combinational OR of sw_chg
// -----------------------------------------------------------------------------
module switch_debounce3 #(
   parameter int DB_CYCLES = 16,
   parameter int CNT_W     = 5
) (
   input  logic       clk,
   input  logic       rst,
   input  logic [2:0] sw_in,
   output logic [2:0] sw_db,
   output logic [2:0] sw_chg,
   output logic       any_chg
);

   localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DB_CYCLES - 1);
   localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

   logic [2:0]       s1_q;
   logic [2:0]       s2_q;
   logic [2:0]       lvl_q;     // internal stable (filtered) level
   logic [2:0]       chg_q;
   logic [CNT_W-1:0] cnt_q [3];

   logic [2:0]       diff;      // synchronised input disagrees with stable level
   logic [2:0]       done;      // disagreement has lasted DB_CYCLES edges
   logic [2:0]       chg_d;

   // Two-flop synchroniser; only s2_q is used downstream.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         s1_q <= '0;
         s2_q <= '0;
      end else begin
         s1_q <= sw_in;
         s2_q <= s1_q;
      end
   end

   always_comb begin
      diff = s2_q ^ lvl_q;
      done = '0;
      for (int i = 0; i < 3; i++) begin
         done[i] = diff[i] && (cnt_q[i] == CNT_LAST);
      end
   end

   // Stability counters and stable level. The counter is cleared both on
   // agreement and on qualification, so it never exceeds DB_CYCLES-1.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         for (int i = 0; i < 3; i++) begin
            cnt_q[i] <= '0;
         end
         lvl_q <= '0;
      end else begin
         for (int i = 0; i < 3; i++) begin
            if (!diff[i] || done[i]) begin
               cnt_q[i] <= '0;
            end else begin
               cnt_q[i] <= cnt_q[i] + CNT_ONE;
            end
         end
         // done is only set where the level disagrees, so flipping those
         // bits copies s2_q into the stable level.
         lvl_q <= lvl_q ^ done;
      end
   end

`ifdef SWITCH_DEBOUNCE3_TOGGLE_EN
   logic [2:0] tog_q;

   // Only qualified rising transitions (new level 1) toggle the output.
   assign chg_d = done & s2_q;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         tog_q <= '0;
      end else begin
         tog_q <= tog_q ^ chg_d;
      end
   end

   assign sw_db = tog_q;
`else
   assign chg_d = done;
   assign sw_db = lvl_q;
`endif

   // Strobe is registered alongside the output update, so it is high for
   // exactly the cycle after the edge that changed sw_db.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         chg_q <= '0;
      end else begin
         chg_q <= chg_d;
      end
   end

   assign sw_chg  = chg_q;
   assign any_chg = |chg_q;

endmodule

// File: tb/tb_switch_debounce3.sv
// -----------------------------------------------------------------------------
// tb_switch_debounce3
//
// Bench for switch_debounce3 with DB_CYCLES=16. Inputs are driven on the
// falling clock edge; outputs are sampled on the falling edge. An input level
// driven at the falling edge after rising edge N must appear on sw_db after
// rising edge N+LAT (LAT = DB_CYCLES+2: two synchroniser edges plus the
// qualification edges), with sw_chg high during the following cycle.
// Expected strobe events {edge, sw_db, sw_chg} are queued when stimulus is
// driven and popped by the monitor whenever the DUT raises a strobe.
// Build with +define+SWITCH_DEBOUNCE3_TOGGLE_EN to run the push-button test.
// -----------------------------------------------------------------------------
module tb_switch_debounce3;

   localparam int DB  = 16;
   localparam int LAT = DB + 2;
   localparam int W   = 38;   // {edge[31:0], sw_db[2:0], sw_chg[2:0]}

   // ---------------- clock / reset ----------------
   logic       clk = 1'b0;
   logic       rst = 1'b1;
   logic [2:0] sw_in = 3'b000;
   logic [2:0] sw_db;
   logic [2:0] sw_chg;
   logic       any_chg;

   always #5 clk = ~clk;

   int edge_n = 0;
   always @(posedge clk) edge_n = edge_n + 1;

   switch_debounce3 #(
      .DB_CYCLES (DB),
      .CNT_W     (5)
   ) dut (
      .clk     (clk),
      .rst     (rst),
      .sw_in   (sw_in),
      .sw_db   (sw_db),
      .sw_chg  (sw_chg),
      .any_chg (any_chg)
   );

   // ---------------- scoreboard ----------------
   logic [W-1:0] exp_q[$];
   int checks = 0;
   int errors = 0;

   always @(negedge clk) begin
      logic [W-1:0] e;
      checks++;
      if (any_chg !== (|sw_chg)) begin
         errors++;
         $display("FAIL any_chg_or: any_chg=%b sw_chg=%b at edge %0d", any_chg, sw_chg, edge_n);
      end
      if (sw_chg !== 3'b000) begin
         checks++;
         if (exp_q.size() == 0) begin
            errors++;
            $display("FAIL unexpected_chg: sw_chg=%b sw_db=%b at edge %0d, no change expected",
                     sw_chg, sw_db, edge_n);
         end else begin
            e = exp_q.pop_front();
            if (edge_n !== int'(e[37:6]) || sw_db !== e[5:3] || sw_chg !== e[2:0]) begin
               errors++;
               $display("FAIL chg_event: got edge %0d db=%b chg=%b, expected edge %0d db=%b chg=%b",
                        edge_n, sw_db, sw_chg, int'(e[37:6]), e[5:3], e[2:0]);
            end
         end
      end
   end

   // ---------------- driver tasks ----------------
   // Queue a change expected from the input level about to be driven now.
   task automatic push_exp(input logic [2:0] db, input logic [2:0] chg);
      exp_q.push_back({edge_n + LAT, db, chg});
   endtask

   // Drive a level at the current falling edge and hold it for n cycles.
   task automatic step(input logic [2:0] v, input int n);
      sw_in = v;
      repeat (n) @(negedge clk);
   endtask

`ifndef SWITCH_DEBOUNCE3_TOGGLE_EN
   // ---------------- tests (level mode) ----------------
   task automatic test_reset;
      int rel;
      logic [2:0] exp;
      rst   = 1'b1;
      sw_in = 3'b111;
      repeat (3) @(negedge clk);
      checks++;
      if (sw_db !== 3'b000 || sw_chg !== 3'b000 || any_chg !== 1'b0) begin
         errors++;
         $display("FAIL reset_state: sw_db=%b sw_chg=%b any_chg=%b, expected 000/000/0",
                  sw_db, sw_chg, any_chg);
      end
      push_exp(3'b111, 3'b111);
      rel = edge_n + LAT;
      rst = 1'b0;
      for (int i = 0; i < 22; i++) begin
         @(negedge clk);
         exp = (edge_n >= rel) ? 3'b111 : 3'b000;
         checks++;
         if (sw_db !== exp) begin
            errors++;
            $display("FAIL reset_release_db: edge %0d sw_db=%b, expected %b", edge_n, sw_db, exp);
         end
      end
      checks++;
      if (exp_q.size() != 0) begin
         errors++;
         $display("FAIL reset_release_pending: %0d expected changes never seen", exp_q.size());
      end
   endtask

   task automatic test_fall_all;
      push_exp(3'b000, 3'b111);
      step(3'b000, 22);
      checks++;
      if (sw_db !== 3'b000 || exp_q.size() != 0) begin
         errors++;
         $display("FAIL fall_all: sw_db=%b pending=%0d, expected 000 and 0", sw_db, exp_q.size());
      end
   endtask

   task automatic test_glitch;
      step(3'b001, 10);
      step(3'b000, 25);
      checks++;
      if (sw_db !== 3'b000) begin
         errors++;
         $display("FAIL glitch_10: sw_db=%b, expected 000", sw_db);
      end
      // One cycle short of qualifying.
      step(3'b001, DB - 1);
      step(3'b000, 25);
      checks++;
      if (sw_db !== 3'b000) begin
         errors++;
         $display("FAIL glitch_short: sw_db=%b, expected 000", sw_db);
      end
      // Exactly long enough to qualify, then released.
      push_exp(3'b001, 3'b001);
      step(3'b001, DB);
      push_exp(3'b000, 3'b001);
      step(3'b000, 25);
      checks++;
      if (sw_db !== 3'b000 || exp_q.size() != 0) begin
         errors++;
         $display("FAIL glitch_exact: sw_db=%b pending=%0d, expected 000 and 0", sw_db, exp_q.size());
      end
   endtask

   task automatic test_single;
      push_exp(3'b010, 3'b010);
      step(3'b010, 25);
      checks++;
      if (sw_db !== 3'b010 || exp_q.size() != 0) begin
         errors++;
         $display("FAIL single_rise: sw_db=%b pending=%0d, expected 010 and 0", sw_db, exp_q.size());
      end
      push_exp(3'b000, 3'b010);
      step(3'b000, 22);
      checks++;
      if (sw_db !== 3'b000) begin
         errors++;
         $display("FAIL single_fall: sw_db=%b, expected 000", sw_db);
      end
   endtask

   task automatic test_burst;
      for (int s = 0; s < 10; s++) begin
         step((s % 2 == 0) ? 3'b100 : 3'b000, 3);
      end
      push_exp(3'b100, 3'b100);
      step(3'b100, 22);
      checks++;
      if (sw_db !== 3'b100 || exp_q.size() != 0) begin
         errors++;
         $display("FAIL burst: sw_db=%b pending=%0d, expected 100 and 0", sw_db, exp_q.size());
      end
      push_exp(3'b000, 3'b100);
      step(3'b000, 22);
   endtask

   task automatic test_simultaneous;
      push_exp(3'b011, 3'b011);
      step(3'b011, 22);
      checks++;
      if (sw_db !== 3'b011) begin
         errors++;
         $display("FAIL simul_rise: sw_db=%b, expected 011", sw_db);
      end
      // Staggered release: bit1 first, bit0 five cycles later.
      push_exp(3'b001, 3'b010);
      step(3'b001, 5);
      push_exp(3'b000, 3'b001);
      step(3'b000, 22);
      checks++;
      if (sw_db !== 3'b000 || exp_q.size() != 0) begin
         errors++;
         $display("FAIL simul_stagger: sw_db=%b pending=%0d, expected 000 and 0", sw_db, exp_q.size());
      end
   endtask

   task automatic test_reset_mid;
      int rel;
      logic [2:0] exp;
      push_exp(3'b010, 3'b010);
      step(3'b010, 20);
      step(3'b101, 10);        // partial counts in flight on all channels
      #2 rst = 1'b1;
      #1;
      checks++;
      if (sw_db !== 3'b000 || sw_chg !== 3'b000 || any_chg !== 1'b0) begin
         errors++;
         $display("FAIL async_reset: sw_db=%b sw_chg=%b any_chg=%b, expected 000/000/0",
                  sw_db, sw_chg, any_chg);
      end
      repeat (2) @(negedge clk);
      push_exp(3'b101, 3'b101);
      rel = edge_n + LAT;
      rst = 1'b0;
      for (int i = 0; i < 24; i++) begin
         @(negedge clk);
         exp = (edge_n >= rel) ? 3'b101 : 3'b000;
         checks++;
         if (sw_db !== exp) begin
            errors++;
            $display("FAIL reset_mid_db: edge %0d sw_db=%b, expected %b", edge_n, sw_db, exp);
         end
      end
      checks++;
      if (exp_q.size() != 0) begin
         errors++;
         $display("FAIL reset_mid_pending: %0d expected changes never seen", exp_q.size());
      end
   endtask
`else
   // ---------------- tests (push-button mode) ----------------
   task automatic test_toggle;
      rst   = 1'b1;
      sw_in = 3'b000;
      repeat (2) @(negedge clk);
      checks++;
      if (sw_db !== 3'b000 || sw_chg !== 3'b000) begin
         errors++;
         $display("FAIL toggle_reset: sw_db=%b sw_chg=%b, expected 000/000", sw_db, sw_chg);
      end
      rst = 1'b0;
      push_exp(3'b001, 3'b001);
      step(3'b001, 20);
      checks++;
      if (sw_db !== 3'b001) begin
         errors++;
         $display("FAIL toggle_press1: sw_db=%b, expected 001", sw_db);
      end
      step(3'b000, 20);
      checks++;
      if (sw_db !== 3'b001) begin
         errors++;
         $display("FAIL toggle_release1: sw_db=%b, expected 001", sw_db);
      end
      push_exp(3'b000, 3'b001);
      step(3'b001, 20);
      checks++;
      if (sw_db !== 3'b000) begin
         errors++;
         $display("FAIL toggle_press2: sw_db=%b, expected 000", sw_db);
      end
      step(3'b000, 20);
      checks++;
      if (sw_db !== 3'b000 || exp_q.size() != 0) begin
         errors++;
         $display("FAIL toggle_release2: sw_db=%b pending=%0d, expected 000 and 0", sw_db, exp_q.size());
      end
   endtask
`endif

   // ---------------- sequence and report ----------------
   initial begin
`ifndef SWITCH_DEBOUNCE3_TOGGLE_EN
      test_reset();
      test_fall_all();
      test_glitch();
      test_single();
      test_burst();
      test_simultaneous();
      test_reset_mid();
`else
      test_toggle();
`endif
      repeat (2) @(negedge clk);
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
